switch_debouncer: RTL and testbench

//  Conditions the raw board push-switches before they reach io_bus.switch (the CPU IN port).

---
 rtl/debounce_pkg.sv | 15 +
 rtl/switch_debouncer_if.sv | 13 +
 rtl/debounce_bit.sv | 86 ++++++++
 rtl/switch_debouncer.sv | 56 +++++
 tb/tb_switch_debouncer.sv | 338 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/debounce_pkg.sv
// Shared sizing helpers for the switch debouncer.
// Callers pass in their configuration parameters to get the register widths they need.
package debounce_pkg;

  // Width of a counter that must hold values 0..stable_count.
  function automatic int cnt_w(input int stable_count);
    return $clog2(stable_count + 1);
  endfunction

  // Width of the 0..sample_div-1 tick counter. The width never drops below one bit.
  function automatic int tick_w(input int sample_div);
    return (sample_div > 1) ? $clog2(sample_div) : 1;
  endfunction

endpackage

// File: rtl/switch_debouncer_if.sv
// Switch bundle between the board pins and the debouncer outputs.
// master: the side that drives the raw pins and observes the results. slave: the debouncer.
interface switch_debouncer_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] switch_raw;
  logic [WIDTH-1:0] switch_db;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;

  modport master (output switch_raw, input switch_db, input rise, input fall);
  modport slave  (input switch_raw, output switch_db, output rise, output fall);
endinterface

// File: rtl/debounce_bit.sv
// One switch bit: 2-flop synchroniser, stability counter, debounced level and optional edge pulses.
// The edge pulses are only built when DEBOUNCE_EDGE_EN is defined. Otherwise rise and fall are tied low.
module debounce_bit
  import debounce_pkg::*;
#(
  parameter int STABLE_COUNT = 16
) (
  input  logic clk,
  input  logic n_reset,
  input  logic tick,
  input  logic raw,
  output logic db,
  output logic rise,
  output logic fall
);

  localparam int CW = cnt_w(STABLE_COUNT);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_COUNT - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          db_q, db_d;

  always_comb begin
    sync1_d = raw;
    sync2_d = sync1_q;
    cnt_d   = cnt_q;
    db_d    = db_q;
    // Any agreeing cycle restarts qualification, so bounces of any length reset the count.
    if (sync2_q == db_q) begin
      cnt_d = '0;
    end else if (tick) begin
      if (cnt_q >= CNT_LAST) begin
        db_d  = sync2_q;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      db_q    <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      cnt_q   <= cnt_d;
      db_q    <= db_d;
    end
  end

  assign db = db_q;

`ifdef DEBOUNCE_EDGE_EN
  logic rise_q, rise_d;
  logic fall_q, fall_d;

  // The pulses are registered with the level, so they line up with the new switch_db value.
  always_comb begin
    rise_d = db_d & ~db_q;
    fall_d = ~db_d & db_q;
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign rise = rise_q;
  assign fall = fall_q;
`else
  assign rise = 1'b0;
  assign fall = 1'b0;
`endif

endmodule

// File: rtl/switch_debouncer.sv
// Debounces WIDTH raw push-switches on the board clock using a shared sample tick.
// Optional rise/fall pulses are enabled with the DEBOUNCE_EDGE_EN macro.
module switch_debouncer
  import debounce_pkg::*;
#(
  parameter int WIDTH        = 4,
  parameter int SAMPLE_DIV   = 100_000,
  parameter int STABLE_COUNT = 16
) (
  input  logic               clk,
  input  logic               n_reset,
  switch_debouncer_if.slave  bus
);

  localparam int TW = tick_w(SAMPLE_DIV);
  localparam logic [TW-1:0] TICK_LAST = TW'(SAMPLE_DIV - 1);

  logic [TW-1:0]    tick_cnt_q, tick_cnt_d;
  logic             tick;
  logic [WIDTH-1:0] db_w;
  logic [WIDTH-1:0] rise_w;
  logic [WIDTH-1:0] fall_w;

  // The tick is decoded from the counter register, so it is high for exactly one cycle per period.
  always_comb begin
    tick       = (tick_cnt_q == TICK_LAST);
    tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    debounce_bit #(
      .STABLE_COUNT (STABLE_COUNT)
    ) u_bit (
      .clk     (clk),
      .n_reset (n_reset),
      .tick    (tick),
      .raw     (bus.switch_raw[i]),
      .db      (db_w[i]),
      .rise    (rise_w[i]),
      .fall    (fall_w[i])
    );
  end

  assign bus.switch_db = db_w;
  assign bus.rise      = rise_w;
  assign bus.fall      = fall_w;

endmodule

// File: tb/tb_switch_debouncer.sv
// Self-checking bench for switch_debouncer (WIDTH=4, SAMPLE_DIV=4, STABLE_COUNT=3).
// A tick-counting reference model feeds an expected queue of {fall, rise, switch_db}, one entry per clock.
module tb_switch_debouncer;

  localparam int W  = 4;
  localparam int D  = 4;
  localparam int SC = 3;
  localparam int EW = 3 * W;
`ifdef DEBOUNCE_EDGE_EN
  localparam bit EDGE = 1'b1;
`else
  localparam bit EDGE = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic n_reset = 1'b0;
  always #5 clk = ~clk;

  switch_debouncer_if #(.WIDTH(W)) bus ();

  switch_debouncer #(
    .WIDTH        (W),
    .SAMPLE_DIV   (D),
    .STABLE_COUNT (SC)
  ) dut (
    .clk     (clk),
    .n_reset (n_reset),
    .bus     (bus)
  );

  int checks   = 0;
  int failures = 0;
  logic [EW-1:0] exp_q[$];

  // reference model: a level is accepted once SC ticks have passed since sync last agreed with it
  logic [W-1:0] raw_hist[$];
  logic [W-1:0] m_db, m_rise, m_fall, sync_now;
  longint       cyc;
  longint       last_agree[W];
  bit           is_tick;

  function automatic longint ticks_upto(input longint c);
    return (c + 1) / D;
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      m_rise = '0;
      m_fall = '0;
      if (!n_reset) begin
        raw_hist.delete();
        raw_hist.push_back('0);
        raw_hist.push_back('0);
        m_db = '0;
        cyc  = 0;
        for (int i = 0; i < W; i++) last_agree[i] = -1;
      end else begin
        sync_now = raw_hist.pop_front();
        raw_hist.push_back(bus.switch_raw);
        is_tick = ((cyc % D) == D - 1);
        for (int i = 0; i < W; i++) begin
          if (sync_now[i] == m_db[i]) begin
            last_agree[i] = cyc;
          end else if (is_tick && (ticks_upto(cyc) - ticks_upto(last_agree[i]) >= SC)) begin
            m_db[i]       = sync_now[i];
            m_rise[i]     = sync_now[i];
            m_fall[i]     = ~sync_now[i];
            last_agree[i] = cyc;
          end
        end
        cyc++;
      end
      if (!EDGE) begin
        m_rise = '0;
        m_fall = '0;
      end
      exp_q.push_back({m_fall, m_rise, m_db});
    end
  end

  // driver: advance one clock and fetch the model's expectation for it
  task automatic next_cycle(output logic [EW-1:0] e);
    @(negedge clk);
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else e = 'x;
  endtask

  task automatic test_reset();
    logic [EW-1:0] e;
    int first;
    n_reset = 1'b0;
    bus.switch_raw = 4'hF;
    repeat (5) begin
      next_cycle(e);
      checks++;
      if ({bus.fall, bus.rise, bus.switch_db} !== {EW{1'b0}}) begin
        failures++;
        $display("FAIL reset_hold: got %h want 0", {bus.fall, bus.rise, bus.switch_db});
      end
    end
    n_reset = 1'b1;
    first = 0;
    for (int k = 1; k <= 30; k++) begin
      next_cycle(e);
      checks++;
      if ({bus.fall, bus.rise, bus.switch_db} !== e) begin
        failures++;
        $display("FAIL reset_model k=%0d: got %h want %h", k, {bus.fall, bus.rise, bus.switch_db}, e);
      end
      if (first == 0 && bus.switch_db !== 4'h0) first = k;
    end
    checks++;
    if (first < 11 || first > 15) begin
      failures++;
      $display("FAIL reset_release_latency: got %0d want 11..15", first);
    end
  endtask

  task automatic test_clean_press();
    logic [EW-1:0] e;
    int lat, rise_cnt, fall_cnt;
    bus.switch_raw = 4'h0;
    n_reset = 1'b0;
    next_cycle(e);
    n_reset = 1'b1;
    repeat ($urandom_range(0, 7)) next_cycle(e);
    bus.switch_raw = 4'h1;
    lat = 0; rise_cnt = 0; fall_cnt = 0;
    for (int k = 1; k <= 25; k++) begin
      next_cycle(e);
      checks++;
      if ({bus.fall, bus.rise, bus.switch_db} !== e) begin
        failures++;
        $display("FAIL press_model k=%0d: got %h want %h", k, {bus.fall, bus.rise, bus.switch_db}, e);
      end
      if (lat == 0 && bus.switch_db === 4'h1) begin
        lat = k;
        checks++;
        if (bus.rise !== (EDGE ? 4'h1 : 4'h0)) begin
          failures++;
          $display("FAIL press_rise_align: got %h want %h", bus.rise, EDGE ? 4'h1 : 4'h0);
        end
      end
      if (bus.rise !== 4'h0) rise_cnt++;
      if (bus.fall !== 4'h0) fall_cnt++;
    end
    checks++;
    if (lat < 11 || lat > 15) begin
      failures++;
      $display("FAIL press_latency: got %0d want 11..15", lat);
    end
    checks++;
    if (rise_cnt != (EDGE ? 1 : 0) || fall_cnt != 0) begin
      failures++;
      $display("FAIL press_pulses: got rise=%0d fall=%0d want rise=%0d fall=0", rise_cnt, fall_cnt, EDGE ? 1 : 0);
    end
  endtask

  task automatic test_bounce();
    logic [EW-1:0] e;
    int lat;
    for (int k = 0; k < 40; k++) begin
      if (k % 3 == 0) bus.switch_raw[2] = ~bus.switch_raw[2];
      next_cycle(e);
      checks++;
      if ({bus.fall, bus.rise, bus.switch_db} !== e || bus.switch_db[2] !== 1'b0) begin
        failures++;
        $display("FAIL bounce_hold k=%0d: got %h want %h with db[2]=0", k, {bus.fall, bus.rise, bus.switch_db}, e);
      end
    end
    bus.switch_raw[2] = 1'b1;
    lat = 0;
    for (int k = 1; k <= 25; k++) begin
      next_cycle(e);
      checks++;
      if ({bus.fall, bus.rise, bus.switch_db} !== e) begin
        failures++;
        $display("FAIL bounce_model k=%0d: got %h want %h", k, {bus.fall, bus.rise, bus.switch_db}, e);
      end
      if (lat == 0 && bus.switch_db[2] === 1'b1) lat = k;
    end
    checks++;
    if (lat < 1 || lat > 15) begin
      failures++;
      $display("FAIL bounce_settle: got %0d want 1..15", lat);
    end
  endtask

  task automatic test_glitch();
    logic [EW-1:0] e;
    int settled;
    bus.switch_raw = 4'hF;
    settled = 0;
    for (int k = 1; k <= 40; k++) begin
      next_cycle(e);
      checks++;
      if ({bus.fall, bus.rise, bus.switch_db} !== e) begin
        failures++;
        $display("FAIL glitch_settle_model k=%0d: got %h want %h", k, {bus.fall, bus.rise, bus.switch_db}, e);
      end
      if (bus.switch_db === 4'hF) settled = 1;
    end
    checks++;
    if (settled == 0) begin
      failures++;
      $display("FAIL glitch_settle: got %h want f", bus.switch_db);
    end
    for (int k = 0; k < 35; k++) begin
      bus.switch_raw[3] = (k < 5) ? 1'b0 : 1'b1;
      next_cycle(e);
      checks++;
      if ({bus.fall, bus.rise, bus.switch_db} !== e || bus.switch_db !== 4'hF || bus.fall !== 4'h0) begin
        failures++;
        $display("FAIL glitch_hold k=%0d: got %h want %h with db=f fall=0", k, {bus.fall, bus.rise, bus.switch_db}, e);
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [EW-1:0] e;
    int seen;
    bus.switch_raw = 4'h0;
    for (int k = 1; k <= 40; k++) begin
      next_cycle(e);
      checks++;
      if ({bus.fall, bus.rise, bus.switch_db} !== e) begin
        failures++;
        $display("FAIL simul_clear_model k=%0d: got %h want %h", k, {bus.fall, bus.rise, bus.switch_db}, e);
      end
    end
    bus.switch_raw = 4'hA;
    seen = 0;
    for (int k = 1; k <= 25; k++) begin
      next_cycle(e);
      checks++;
      if ({bus.fall, bus.rise, bus.switch_db} !== e) begin
        failures++;
        $display("FAIL simul_model k=%0d: got %h want %h", k, {bus.fall, bus.rise, bus.switch_db}, e);
      end
      if (seen == 1) begin
        seen = 2;
        checks++;
        if (bus.rise !== 4'h0) begin
          failures++;
          $display("FAIL simul_rise_width: got %h want 0", bus.rise);
        end
      end
      if (seen == 0 && bus.switch_db !== 4'h0) begin
        seen = 1;
        checks++;
        if (bus.switch_db !== 4'hA || bus.rise !== (EDGE ? 4'hA : 4'h0)) begin
          failures++;
          $display("FAIL simul_same_cycle: got db=%h rise=%h want db=a rise=%h", bus.switch_db, bus.rise, EDGE ? 4'hA : 4'h0);
        end
      end
    end
    checks++;
    if (seen != 2) begin
      failures++;
      $display("FAIL simul_seen: got %0d want 2", seen);
    end
  endtask

  task automatic test_reset_mid();
    logic [EW-1:0] e;
    int lat;
    bus.switch_raw = 4'h0;
    n_reset = 1'b0;
    next_cycle(e);
    n_reset = 1'b1;
    bus.switch_raw = 4'h1;
    repeat (8) begin
      next_cycle(e);
      checks++;
      if ({bus.fall, bus.rise, bus.switch_db} !== e) begin
        failures++;
        $display("FAIL midreset_pre: got %h want %h", {bus.fall, bus.rise, bus.switch_db}, e);
      end
    end
    n_reset = 1'b0;
    next_cycle(e);
    n_reset = 1'b1;
    lat = 0;
    for (int k = 1; k <= 25; k++) begin
      next_cycle(e);
      checks++;
      if ({bus.fall, bus.rise, bus.switch_db} !== e) begin
        failures++;
        $display("FAIL midreset_model k=%0d: got %h want %h", k, {bus.fall, bus.rise, bus.switch_db}, e);
      end
      if (lat == 0 && bus.switch_db[0] === 1'b1) lat = k;
    end
    checks++;
    if (lat < 11 || lat > 15) begin
      failures++;
      $display("FAIL midreset_latency: got %0d want 11..15", lat);
    end
  endtask

  task automatic test_random();
    logic [EW-1:0] e;
    for (int k = 0; k < 600; k++) begin
      n_reset = ($urandom_range(0, 249) == 0) ? 1'b0 : 1'b1;
      if ($urandom_range(0, 11) == 0) bus.switch_raw[$urandom_range(0, W - 1)] ^= 1'b1;
      next_cycle(e);
      checks++;
      if ({bus.fall, bus.rise, bus.switch_db} !== e) begin
        failures++;
        $display("FAIL random_model k=%0d: got %h want %h", k, {bus.fall, bus.rise, bus.switch_db}, e);
      end
    end
    n_reset = 1'b1;
  endtask

  initial begin
    bus.switch_raw = 4'hF;
    test_reset();
    test_clean_press();
    test_bounce();
    test_glitch();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    failures++;
    $display("FAIL watchdog: got timeout want finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
